// File: rtl/pipe_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_sequencer_if
// Description : Decode/EX hazard inputs and pipeline control/status bundle
//               for pipe_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             go;
    logic [3:0]       id_readReg0;
    logic [3:0]       id_readReg1;
    logic             id_uses_r0;
    logic             id_uses_r1;
    logic             id_halt;
    logic             ex_write;
    logic             ex_MemtoReg;
    logic [3:0]       ex_write_reg;
    logic             ex_branch_taken;
    logic             pc_clr;
    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] stall_cnt;

    // Pipeline side: supplies stage information, consumes controls.
    modport master (
        output go, id_readReg0, id_readReg1, id_uses_r0, id_uses_r1, id_halt,
               ex_write, ex_MemtoReg, ex_write_reg, ex_branch_taken,
        input  pc_clr, pc_en, if_id_en, if_id_flush, id_ex_flush,
               busy, done, cycle_cnt, stall_cnt
    );

    // Sequencer side.
    modport slave (
        input  go, id_readReg0, id_readReg1, id_uses_r0, id_uses_r1, id_halt,
               ex_write, ex_MemtoReg, ex_write_reg, ex_branch_taken,
        output pc_clr, pc_en, if_id_en, if_id_flush, id_ex_flush,
               busy, done, cycle_cnt, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pipe_sequencer
// Description : Run/stall/flush/halt sequencer for the 9-bit pipelined CPU.
//               Optional performance counters: PIPE_SEQ_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_sequencer #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  wire logic       clk,
    input  wire logic       reset,
    pipe_sequencer_if.slave seq
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    localparam logic [3:0] c_DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [3:0] r_drain_cnt;
    logic [3:0] w_drain_nxt;
    logic       r_busy;
    logic       r_done;

    logic       w_hazard;
    logic       w_stall;
    logic       w_active;
    logic       w_pc_clr;
    logic       w_pc_en;
    logic       w_if_id_en;
    logic       w_if_id_flush;
    logic       w_id_ex_flush;

    assign w_hazard = seq.ex_write && seq.ex_MemtoReg &&
                      ((seq.id_uses_r0 && (seq.ex_write_reg == seq.id_readReg0)) ||
                       (seq.id_uses_r1 && (seq.ex_write_reg == seq.id_readReg1)));

    always_comb begin
        w_state_nxt   = r_state;
        w_drain_nxt   = r_drain_cnt;
        w_pc_clr      = 1'b0;
        w_pc_en       = 1'b0;
        w_if_id_en    = 1'b0;
        w_if_id_flush = 1'b1;
        w_id_ex_flush = 1'b1;
        w_stall       = 1'b0;
        w_active      = 1'b0;
        case (r_state)
            S_IDLE, S_HALTED: begin
                if (seq.go) begin
                    w_pc_clr    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_active = 1'b1;
                if (seq.ex_branch_taken) begin
                    // Squash both younger slots; halt/hazard in decode are wrong-path.
                    w_pc_en    = 1'b1;
                    w_if_id_en = 1'b1;
                end else if (seq.id_halt) begin
                    w_if_id_en  = 1'b1;
                    w_state_nxt = S_DRAIN;
                    w_drain_nxt = c_DRAIN_LOAD;
                end else if (w_hazard) begin
                    w_if_id_flush = 1'b0;
                    w_stall       = 1'b1;
                end else begin
                    w_pc_en       = 1'b1;
                    w_if_id_en    = 1'b1;
                    w_if_id_flush = 1'b0;
                    w_id_ex_flush = 1'b0;
                end
            end
            S_DRAIN: begin
                w_active = 1'b1;
                if (r_drain_cnt == 4'd0) begin
                    w_state_nxt = S_HALTED;
                end else begin
                    w_drain_nxt = r_drain_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_drain_cnt <= 4'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
            r_busy      <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
            r_done      <= (w_state_nxt == S_HALTED);
        end
    end

`ifdef PIPE_SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle_cnt <= '0;
            r_stall_cnt <= '0;
        end else if (w_pc_clr) begin
            r_cycle_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_active && (r_cycle_cnt != {CNT_W{1'b1}})) begin
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
            end
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign seq.cycle_cnt = r_cycle_cnt;
    assign seq.stall_cnt = r_stall_cnt;
`else
    logic w_unused;
    assign w_unused      = w_active ^ w_stall;
    assign seq.cycle_cnt = {CNT_W{1'b0}};
    assign seq.stall_cnt = {CNT_W{1'b0}};
`endif

    assign seq.pc_clr      = w_pc_clr;
    assign seq.pc_en       = w_pc_en;
    assign seq.if_id_en    = w_if_id_en;
    assign seq.if_id_flush = w_if_id_flush;
    assign seq.id_ex_flush = w_id_ex_flush;
    assign seq.busy        = r_busy;
    assign seq.done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pipe_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_sequencer
// Description : Directed plus randomized bench for pipe_sequencer against a
//               behavioural model of the run/stall/halt rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_sequencer;

    localparam int DC  = 3;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;
`ifdef PIPE_SEQ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_sequencer_if #(.CNT_W(CW)) bus ();

    pipe_sequencer #(.DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .seq   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: mode 0 idle, 1 running, 2 draining, 3 halted.
    int m_mode;
    int m_left;
    int m_cyc;
    int m_stl;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_left = 0;
        m_cyc  = 0;
        m_stl  = 0;
    endtask

    task automatic set_in(input logic go, input logic [3:0] r0, input logic [3:0] r1,
                          input logic u0, input logic u1, input logic halt,
                          input logic exw, input logic mtr, input logic [3:0] wr,
                          input logic br);
        bus.go              = go;
        bus.id_readReg0     = r0;
        bus.id_readReg1     = r1;
        bus.id_uses_r0      = u0;
        bus.id_uses_r1      = u1;
        bus.id_halt         = halt;
        bus.ex_write        = exw;
        bus.ex_MemtoReg     = mtr;
        bus.ex_write_reg    = wr;
        bus.ex_branch_taken = br;
    endtask

    task automatic check_regs();
        check("busy", 32'(bus.busy), 32'((m_mode == 1) || (m_mode == 2)));
        check("done", 32'(bus.done), 32'(m_mode == 3));
        check("cycle_cnt", 32'(bus.cycle_cnt), PERF ? m_cyc : 0);
        check("stall_cnt", 32'(bus.stall_cnt), PERF ? m_stl : 0);
    endtask

    // Inputs are already applied; check combinational controls, then advance one edge.
    task automatic cycle();
        bit hz;
        int e_clr, e_pc, e_ifen, e_iff, e_ief;
        #2;
        hz = bus.ex_write && bus.ex_MemtoReg &&
             ((bus.id_uses_r0 && bus.ex_write_reg == bus.id_readReg0) ||
              (bus.id_uses_r1 && bus.ex_write_reg == bus.id_readReg1));
        e_clr = 0; e_pc = 0; e_ifen = 0; e_iff = 1; e_ief = 1;
        if (m_mode == 0 || m_mode == 3) begin
            e_clr = int'(bus.go);
        end else if (m_mode == 1) begin
            if (bus.ex_branch_taken) begin
                e_pc = 1; e_ifen = 1;
            end else if (bus.id_halt) begin
                e_ifen = -1;
            end else if (hz) begin
                e_iff = 0;
            end else begin
                e_pc = 1; e_ifen = 1; e_iff = 0; e_ief = 0;
            end
        end
        check("pc_clr", 32'(bus.pc_clr), e_clr);
        check("pc_en", 32'(bus.pc_en), e_pc);
        if (e_ifen >= 0) check("if_id_en", 32'(bus.if_id_en), e_ifen);
        check("if_id_flush", 32'(bus.if_id_flush), e_iff);
        check("id_ex_flush", 32'(bus.id_ex_flush), e_ief);

        case (m_mode)
            0, 3: if (bus.go) begin
                m_mode = 1; m_cyc = 0; m_stl = 0;
            end
            1: begin
                m_cyc = sat_inc(m_cyc);
                if (bus.ex_branch_taken) begin
                end else if (bus.id_halt) begin
                    m_mode = 2; m_left = DC;
                end else if (hz) begin
                    m_stl = sat_inc(m_stl);
                end
            end
            default: begin
                m_cyc  = sat_inc(m_cyc);
                m_left = m_left - 1;
                if (m_left == 0) m_mode = 3;
            end
        endcase
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic idle_in();
        set_in(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic rand_in();
        logic go_r;
        go_r = (m_mode == 1 || m_mode == 2) ? 1'($urandom) : ($urandom_range(3) == 0);
        set_in(go_r, 4'($urandom_range(3)), 4'($urandom_range(3)), 1'($urandom), 1'($urandom),
               $urandom_range(19) == 0, 1'($urandom), 1'($urandom), 4'($urandom_range(3)),
               $urandom_range(7) == 0);
    endtask

    initial begin
        model_reset();
        reset = 1'b1;
        idle_in();
        bus.go = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_regs();
        check("pc_clr_in_reset", 32'(bus.pc_clr), 32'd1);
        check("pc_en_in_reset", 32'(bus.pc_en), 32'd0);
        check("if_id_flush_in_reset", 32'(bus.if_id_flush), 32'd1);
        idle_in();
        reset = 1'b0;
        cycle();

        // Start, then first RUN cycle.
        bus.go = 1'b1; cycle();
        idle_in();     cycle();

        // Load-use stall, then the same registers with uses_r0 cleared.
        set_in(1'b0, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 1'b0); cycle();
        bus.id_uses_r0 = 1'b0; cycle();

        // Taken branch overrides halt and hazard.
        set_in(1'b0, 4'd2, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 1'b1); cycle();

        // go while running has no effect.
        idle_in(); bus.go = 1'b1; cycle();

        // Halt and drain to completion, then restart.
        idle_in(); bus.id_halt = 1'b1; cycle();
        idle_in();
        repeat (DC + 1) cycle();
        bus.go = 1'b1; cycle();
        idle_in(); cycle();

        // Asynchronous reset in the second drain cycle.
        bus.id_halt = 1'b1; cycle();
        idle_in(); cycle();
        reset = 1'b1;
        #1;
        model_reset();
        check_regs();
        check("pc_en_async_rst", 32'(bus.pc_en), 32'd0);
        check("if_id_flush_async_rst", 32'(bus.if_id_flush), 32'd1);
        check("id_ex_flush_async_rst", 32'(bus.id_ex_flush), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_regs();

        // Long run to exercise counter saturation, then random traffic.
        bus.go = 1'b1; cycle();
        idle_in();
        repeat (SAT + 4) cycle();
        for (int i = 0; i < 1500; i++) begin
            rand_in();
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_sequencer.md
# pipe_sequencer

Run/stall/flush/halt sequencer for the 9-bit-instruction pipelined CPU. It sits beside the decode stage and owns the enables and flushes of the PC and the IF/ID and ID/EX pipeline registers. It starts execution on an external `go` pulse and inserts a one-cycle bubble on load-use hazards. It squashes wrong-path instructions on taken branches and jumps, and drains the pipeline after a `halt` reaches decode. It then reports completion.

## Interface
- DRAIN_CYCLES, 3: cycles spent in DRAIN so the EX, MEM and WB occupants retire (1..15).
- CNT_W, 16: width of the performance counters.

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE
- go  in  1  start request; sampled in IDLE/HALTED only
- id_readReg0  in  4  decode-stage read register 0 index
- id_readReg1  in  4  decode-stage read register 1 index
- id_uses_r0  in  1  decode instruction reads readReg0
- id_uses_r1  in  1  decode instruction reads readReg1
- id_halt  in  1  decode instruction is `halt` (control unit `start` output)
- ex_write  in  1  EX-stage instruction writes a register
- ex_MemtoReg  in  1  EX-stage instruction is `ld`
- ex_write_reg  in  4  EX-stage destination index
- ex_branch_taken  in  1  EX-stage branch/jump resolved taken
- pc_clr  out  1  reset PC to 0 this cycle
- pc_en  out  1  PC may advance/load
- if_id_en  out  1  IF/ID register load enable
- if_id_flush  out  1  IF/ID loads a bubble
- id_ex_flush  out  1  ID/EX loads a bubble
- busy  out  1  registered; 1 in RUN or DRAIN
- done  out  1  registered; 1 in HALTED
- cycle_cnt  out  CNT_W  cycles spent in RUN+DRAIN
- stall_cnt  out  CNT_W  load-use stall cycles

## Operation
- States: IDLE (reset), RUN, DRAIN, HALTED. 2-bit encoding.
- IDLE/HALTED:
  - pc_en=0, if_id_en=0, if_id_flush=1, id_ex_flush=1.
  - On go=1: pc_clr=1 for that cycle, then RUN next cycle. HALTED also clears done.
- RUN: the following is evaluated each cycle, in priority order:
  1. ex_branch_taken=1:
     - pc_en=1, if_id_en=1, if_id_flush=1, id_ex_flush=1.
     - The younger two instructions are squashed, including any id_halt and any hazard.
  2. id_halt=1:
     - pc_en=0, if_id_flush=1, id_ex_flush=1.
     - Next state DRAIN. No stall is considered; halt reads no operands.
  3. Load-use stall, when ex_write & ex_MemtoReg & ((id_uses_r0 & ex_write_reg==id_readReg0) | (id_uses_r1 & ex_write_reg==id_readReg1)):
     - pc_en=0, if_id_en=0, if_id_flush=0, id_ex_flush=1.
     - stall_cnt increments.
  4. Otherwise: pc_en=1, if_id_en=1, both flushes 0.
- DRAIN:
  - pc_en=0, if_id_en=0, if_id_flush=1, id_ex_flush=1.
  - The 4-bit drain counter loads DRAIN_CYCLES-1 on entry and decrements each cycle. At 0, next state is HALTED.
  - ex_branch_taken is ignored in DRAIN, because a taken branch older than halt was already handled in RUN.
- go is ignored in RUN and DRAIN.
- Counters:
  - cycle_cnt increments every cycle in RUN or DRAIN.
  - Both counters saturate at all-ones.
  - Both counters clear synchronously on pc_clr.

## Timing
- pc_clr, pc_en, if_id_en, if_id_flush and id_ex_flush are combinational from the registered state and the current-cycle inputs, with zero latency. Consumers register them at the same edge.
- busy, done, state and the counters are registered.
- Reset values: state=IDLE, busy=0, done=0, cycle_cnt=0, stall_cnt=0, drain counter=0.
- Combinational outputs after reset: pc_en=0, if_id_en=0, if_id_flush=1, id_ex_flush=1, pc_clr=go.
- Start latency: busy=1 on the cycle after go is sampled. The first fetch at PC 0 occurs in that cycle.
- Stall latency:
  - Exactly one bubble per load-use hazard.
  - The held instruction re-evaluates the next cycle; by then the load is in MEM and the hazard clears.
- Halt latency: done=1 exactly DRAIN_CYCLES+1 cycles after the cycle id_halt was accepted.
- A reset assertion mid-RUN/DRAIN forces IDLE asynchronously. Counters clear, and all flush outputs assert immediately.

## Configuration
- PIPE_SEQ_PERF_CNT_EN:
  - Defined: cycle_cnt and stall_cnt are implemented as described.
  - Undefined: no counter flops exist, and both outputs are tied to 0. Other behaviour is identical.

## Test plan
- Reset then go=1 for 1 cycle:
  - pc_clr=1 in the go cycle, then busy=1 and pc_en=1 the next cycle.
  - cycle_cnt=1 after that first RUN cycle.
- Load-use stall, with ex_write=1, ex_MemtoReg=1, ex_write_reg=2, id_readReg0=2, id_uses_r0=1:
  - pc_en=0, if_id_en=0, id_ex_flush=1 for one cycle; stall_cnt=1.
  - With id_uses_r0=0, no stall occurs.
- Branch and hazard together, with ex_branch_taken=1 plus the hazard above and id_halt=1 in the same cycle:
  - if_id_flush=1, id_ex_flush=1, pc_en=1; state stays RUN.
  - stall_cnt is unchanged.
- Halt drain, with id_halt=1 and DRAIN_CYCLES=3:
  - pc_en=0 from acceptance onward; busy stays 1 for 3 DRAIN cycles.
  - done=1 on the 4th cycle after acceptance.
  - A following go=1 gives pc_clr=1, done=0, then RUN, with counters cleared.
- Reset asserted in the 2nd DRAIN cycle:
  - state=IDLE, busy=0, counters=0 immediately.
  - go during RUN has no effect on pc_clr.
- Build without PIPE_SEQ_PERF_CNT_EN and repeat the stall test: stall_cnt=0 and cycle_cnt=0 throughout.
